// File: rtl/popcount_seq_ctrl.sv
// Iterative popcount: one shared CHUNK_WIDTH-bit slice walks the operand over NUM_CHUNKS cycles.
// Latency NUM_CHUNKS edges from accept (1..NUM_CHUNKS with POPCOUNT_EARLY_EXIT_EN); enable=0 freezes BUSY.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, one cycle after retirement.
module popcount_seq_ctrl #(
  parameter int DATA_WIDTH  = 256,
  parameter int CHUNK_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] pop_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] pop_out,
  output logic                  busy
);

  localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
  localparam int ACC_W      = $clog2(DATA_WIDTH + 1);
  localparam int SLICE_W    = $clog2(CHUNK_WIDTH + 1);
  localparam int CTR_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CTR_W-1:0] LAST_CHUNK = CTR_W'(NUM_CHUNKS - 1);

  generate
    if (DATA_WIDTH % CHUNK_WIDTH != 0) begin : g_bad_width
      $error("DATA_WIDTH must be an integer multiple of CHUNK_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [ACC_W-1:0]      acc_q;
  logic [CTR_W-1:0]      ctr_q;

  logic [SLICE_W-1:0]    slice_cnt;
  logic [ACC_W-1:0]      acc_sum;
  logic [DATA_WIDTH-1:0] shift_next;
  logic                  finish;

  // Shared slice: counts the low chunk of the shift register.
  always_comb begin
    slice_cnt = '0;
    for (int i = 0; i < CHUNK_WIDTH; i++) begin
      slice_cnt = slice_cnt + SLICE_W'(shift_q[i]);
    end
  end

  assign acc_sum    = acc_q + ACC_W'(slice_cnt);
  assign shift_next = shift_q >> CHUNK_WIDTH;

`ifdef POPCOUNT_EARLY_EXIT_EN
  assign finish = (ctr_q == LAST_CHUNK) || (shift_next == '0);
`else
  assign finish = (ctr_q == LAST_CHUNK);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      pop_out   <= '0;
      shift_q   <= '0;
      acc_q     <= '0;
      ctr_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            shift_q  <= pop_in;
            acc_q    <= '0;
            ctr_q    <= '0;
            state_q  <= BUSY;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        BUSY: begin
          if (enable) begin
            acc_q   <= acc_sum;
            shift_q <= shift_next;
            ctr_q   <= ctr_q + CTR_W'(1);
            if (finish) begin
              state_q   <= DONE;
              out_valid <= 1'b1;
              pop_out   <= {{(DATA_WIDTH - ACC_W){1'b0}}, acc_sum};
            end
          end
        end
        DONE: begin
          // Retirement goes to IDLE first so no accept can share this edge.
          if (out_ready) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_seq_ctrl.sv
// Randomized bench for popcount_seq_ctrl against a $countones / chunk-remainder reference model.
module tb_popcount_seq_ctrl;

  localparam int DW  = 256;
  localparam int CW  = 32;
  localparam int NCH = DW / CW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] pop_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] pop_out;
  logic          busy;

  int checks = 0;
  int errors = 0;

  popcount_seq_ctrl #(.DATA_WIDTH(DW), .CHUNK_WIDTH(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pop_in    (pop_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pop_out   (pop_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Edges from accept to result: fixed, or first chunk boundary past which nothing is set.
  function automatic int model_lat(input logic [DW-1:0] op);
`ifdef POPCOUNT_EARLY_EXIT_EN
    for (int k = 1; k <= NCH; k++) begin
      if ((op >> (k * CW)) == '0) return k;
    end
    return NCH;
`else
    return NCH;
`endif
  endfunction

  function automatic logic [DW-1:0] rand_op();
    logic [DW-1:0] v;
    int top;
    v = '0;
    top = $urandom_range(NCH - 1, 0);
    for (int c = 0; c <= top; c++) begin
      if ($urandom_range(3, 0) != 0) v[c*CW +: CW] = $urandom;
    end
    return v;
  endfunction

  task automatic run_op(input logic [DW-1:0] op, input int stall_at, input int stall_len, input int hold);
    int n;
    int w;
    bit stalled;
    logic [DW-1:0] exp_pop;
    int exp_lat;
    exp_pop = DW'($countones(op));
    exp_lat = model_lat(op) + stall_len;
    w = 0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    check("in_ready_idle", in_ready, 1);
    pop_in   = op;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    pop_in   = {8{32'($urandom)}};
    check("busy_after_accept", busy, 1);
    check("in_ready_in_busy", in_ready, 0);
    n = 0;
    stalled = 1'b0;
    while (!out_valid && n < 200) begin
      if (!stalled && stall_len > 0 && n == stall_at) begin
        stalled = 1'b1;
        enable = 1'b0;
        repeat (stall_len) begin
          tick();
          n++;
        end
        check("no_result_during_stall", out_valid, 0);
        enable = 1'b1;
      end else begin
        tick();
        n++;
      end
    end
    check("latency", n, exp_lat);
    check("pop_out", pop_out, exp_pop);
    repeat (hold) begin
      in_valid = 1'b1;
      tick();
      check("held_out_valid", out_valid, 1);
      check("held_pop_out", pop_out, exp_pop);
      check("no_accept_in_done", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_valid_retired", out_valid, 0);
    check("in_ready_after_retire", in_ready, 1);
    check("busy_after_retire", busy, 0);
    check("pop_out_holds", pop_out, exp_pop);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] op;
    logic [DW-1:0] ops[3];
    int n;
    int last_acc;
    int cyc;
    bit seen;

    rst_n = 1'b0; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b0; pop_in = '0;
    tick(); tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_pop_out", pop_out, 0);
    rst_n = 1'b1;
    tick();

    op = '1;
    run_op(op, 0, 0, 0);
    op = '0;
    run_op(op, 0, 0, 0);
    op = '0; op[32] = 1'b1; op[1:0] = 2'b11;
    run_op(op, 0, 0, 0);
    op = '0; op[255] = 1'b1;
    run_op(op, 3, 5, 0);
    op = '1;
    run_op(op, 0, 0, 10);

    // Reset at the 4th BUSY edge aborts the operation.
    op = {64{4'hA}};
    pop_in = op; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_pop_out", pop_out, 0);
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_result", seen, 0);
    op = '0; op[7:0] = 8'h0F;
    run_op(op, 0, 0, 0);

    // Back-to-back with in_valid and out_ready held high.
    ops[0] = '0;
    ops[1] = '0; ops[1][127:0] = '1;
    ops[2] = '0; ops[2][36:0] = '1;
    in_valid = 1'b1; out_ready = 1'b1;
    cyc = 0; last_acc = -1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!in_ready && n < 50) begin
        tick(); cyc++; n++;
      end
      pop_in = ops[k];
      tick(); cyc++;
      if (last_acc >= 0) check("b2b_throughput", cyc - last_acc, model_lat(ops[k-1]) + 2);
      last_acc = cyc;
      n = 0;
      while (!out_valid && n < 50) begin
        tick(); cyc++; n++;
      end
      check("b2b_pop_out", pop_out, DW'($countones(ops[k])));
      tick(); cyc++;
      check("b2b_single_result", out_valid, 0);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    tick();

    for (int r = 0; r < 25; r++) begin
      op = rand_op();
      run_op(op, $urandom_range(model_lat(op) - 1, 0), $urandom_range(3, 0), $urandom_range(4, 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/popcount_seq_ctrl.md
Name: popcount_seq_ctrl

Overview:
- Iterative sequencer for the BMI ALU population-count operation.
- Accepts a wide operand over a valid/ready handshake and shares one CHUNK_WIDTH-bit popcount slice across NUM_CHUNKS cycles.
- Accumulates the per-chunk counts and returns the zero-extended total over a second valid/ready handshake.
- Replaces the fully parallel slice array where area matters more than latency.

Parameters:
- DATA_WIDTH, 256: operand and result bus width.
- CHUNK_WIDTH, 32: bits counted per cycle by the shared slice. DATA_WIDTH must be an integer multiple of CHUNK_WIDTH (elaboration error otherwise).
- NUM_CHUNKS, DATA_WIDTH/CHUNK_WIDTH: derived local parameter, not overridable.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- enable  input  1  global stall. When low, BUSY progress freezes; handshakes still evaluate.
- in_valid  input  1  operand valid.
- in_ready  output  1  controller can accept an operand.
- pop_in  input  DATA_WIDTH  operand, sampled on the accept edge.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- pop_out  output  DATA_WIDTH  popcount of the accepted operand, zero-extended.
- busy  output  1  high in BUSY or DONE.

Behaviour:
- Interface: one clock (clk); synchronous, active-low reset (rst_n).
- Reset (rst_n low at an edge):
  - state goes to IDLE; in_ready=1; out_valid=0; busy=0.
  - pop_out=0, accumulator=0, chunk counter=0, operand shift register=0.
- Reset mid-operation: aborts, drops the in-flight operand, no result is produced.
- States are IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - Accept when in_valid=1 at an edge (independent of enable).
  - On accept: shift register <= pop_in, accumulator <= 0, counter <= 0, go to BUSY.
- BUSY:
  - in_ready=0.
  - On each edge with enable=1: accumulator += popcount(shift[CHUNK_WIDTH-1:0]); shift >>= CHUNK_WIDTH; counter++.
  - When the counter reaches NUM_CHUNKS-1 and that chunk is counted, go to DONE and load pop_out with the final sum.
  - enable=0: all registers hold.
- DONE:
  - out_valid=1; pop_out stable until the result is taken.
  - out_ready=1 at an edge: go to IDLE, out_valid falls next cycle.
  - No accept is possible in the same cycle as result retirement; in_ready rises one cycle later.
- Latency (enable held high): out_valid asserts NUM_CHUNKS edges after the accept edge (8 for the defaults). Throughput is one operand per NUM_CHUNKS+2 cycles.
- Width rules:
  - Accumulator width is clog2(DATA_WIDTH+1) bits (9 at defaults); no overflow is possible.
  - pop_out upper bits are always 0.
  - Per-chunk count width is clog2(CHUNK_WIDTH+1).
- Boundary values:
  - All-zero operand gives 0.
  - All-ones operand gives DATA_WIDTH (256, 0x100).
- out_ready while not in DONE: ignored. in_valid while not in IDLE: ignored, and the operand is not captured.
- pop_out holds the last result until the next result load or reset.

Optional Feature:
- Macro: POPCOUNT_EARLY_EXIT_EN.
- Defined:
  - At each BUSY counting edge, if the shifted-out remainder (shift >> CHUNK_WIDTH) is all zero, go to DONE at that edge with the updated sum.
  - Result values are unchanged; latency ranges from 1 to NUM_CHUNKS edges.
  - An operand of 0 finishes 1 edge after accept.
- Undefined: fixed NUM_CHUNKS-edge latency regardless of operand value.

Test Plan:
- Reset then operand 0xFFFF...FF (256 ones) with out_ready=1 -> pop_out=256 with out_valid high exactly 8 edges after accept; in_ready back to 1 two cycles later.
- Operand 0x0000...0001_0000_0003 -> pop_out=3. Latency is 8 edges without the macro; with POPCOUNT_EARLY_EXIT_EN it is 2 edges.
- Operand with bit 255 only set, enable low for 5 cycles mid-BUSY -> pop_out=1; latency 8+5 edges; internal registers frozen during the stall.
- Result backpressure: out_ready=0 for 10 cycles after out_valid -> out_valid and pop_out held stable. A second in_valid pulse during this window is not accepted.
- rst_n driven low for 1 cycle at the 4th BUSY edge of operand 0xAAAA...AA -> out_valid never asserts, in_ready=1, pop_out=0. A following operand 0x0F (4 ones) yields 4.
- Back-to-back: 3 operands with popcounts 0, 128, 37 presented with in_valid held high -> results 0, 128, 37 in order, no drops, no duplicates.
